fb_capture: RTL

//  Write side of the 4-bit palettised framebuffer. Takes one frame of a

---
 rtl/fb_capture.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fb_capture.sv
// Captures one frame of an RGB pixel stream, encodes each pixel to a 4-bit palette index and writes it out.
// Latency: 3 cycles from sampled pixel to fb_we when the buffer is empty; done pulses once the buffer drains.
// Backpressure: fb_ready stalls only the write FIFO; the pixel pipeline free-runs and drops on full (sticky overflow).

module fb_capture_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk_pix,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         push_ok;
    logic         pop_ok;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok     = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

module fb_capture #(
    parameter int CORDW      = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDRW      = 19,
    parameter int FIFO_DEPTH = 16,
    parameter int MISS_IDX   = 3
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             capture_start,
    input  logic             de,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic [7:0]       pix_r,
    input  logic [7:0]       pix_g,
    input  logic [7:0]       pix_b,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr,
    output logic [3:0]       fb_data,
    input  logic             fb_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      miss_count
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;

    localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] Y_LAST = CORDW'(V_RES - 1);
    localparam logic [3:0]       MISS   = 4'(MISS_IDX);
    localparam int               FW     = ADDRW + 4;

    state_t           state_q;
    state_t           state_d;
    logic             done_q;
    logic             done_d;
    logic             overflow_q;
    logic [15:0]      miss_q;
    logic             arm;
    logic             in_frame;
    logic             sample;
    logic             last_pix;

    logic             s1_vld_q;
    logic [5:0]       s1_key_q;
    logic [CORDW-1:0] s1_x_q;
    logic [CORDW-1:0] s1_y_q;
    logic             s2_vld_q;
    logic [ADDRW-1:0] s2_addr_q;
    logic [3:0]       s2_idx_q;

    logic [3:0]       enc_idx;
    logic             enc_hit;
    logic [ADDRW-1:0] x_ext;
    logic [ADDRW-1:0] y_ext;
    logic [ADDRW-1:0] addr_calc;

    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic [FW-1:0]    fifo_head;

    // Only the top two bits of each channel select a palette entry.
    logic             unused_lsbs;
    assign unused_lsbs = ^{pix_r[5:0], pix_g[5:0], pix_b[5:0]};

    assign in_frame = (sx <= X_LAST) && (sy <= Y_LAST);
    assign sample   = de && in_frame &&
                      ((state_q == CAPTURE) || ((state_q == ARMED) && (sx == '0) && (sy == '0)));
    assign last_pix = sample && (sx == X_LAST) && (sy == Y_LAST);
    assign arm      = (state_q == IDLE) && capture_start;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (capture_start) state_d = ARMED;
            ARMED:   if (sample) state_d = last_pix ? FLUSH : CAPTURE;
            CAPTURE: if (last_pix) state_d = FLUSH;
            FLUSH: begin
                if (!s1_vld_q && !s2_vld_q && fifo_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Palette keys are {r,g,b} 2-bit each; all distinct so at most one hits.
    always_comb begin
        enc_hit = 1'b1;
        enc_idx = MISS;
        case (s1_key_q)
            6'b11_11_11: enc_idx = 4'd0;
            6'b10_10_10: enc_idx = 4'd1;
            6'b01_01_01: enc_idx = 4'd2;
            6'b00_00_00: enc_idx = 4'd3;
            6'b11_11_01: enc_idx = 4'd4;
            6'b00_10_00: enc_idx = 4'd5;
            6'b01_11_01: enc_idx = 4'd6;
            6'b11_01_01: enc_idx = 4'd7;
            6'b10_00_00: enc_idx = 4'd8;
            6'b10_01_00: enc_idx = 4'd9;
            6'b10_00_10: enc_idx = 4'd10;
            6'b11_01_11: enc_idx = 4'd11;
            6'b01_11_11: enc_idx = 4'd12;
            6'b00_10_10: enc_idx = 4'd13;
            6'b00_00_10: enc_idx = 4'd14;
            6'b01_01_11: enc_idx = 4'd15;
            default:     enc_hit = 1'b0;
        endcase
    end

    assign x_ext = ADDRW'(s1_x_q);
    assign y_ext = ADDRW'(s1_y_q);

    generate
        if (H_RES == 640) begin : g_addr_640
            assign addr_calc = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_addr_gen
            assign addr_calc = y_ext * ADDRW'(H_RES) + x_ext;
        end
    endgenerate

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            miss_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_key_q   <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_idx_q   <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            s1_vld_q <= sample;
            if (sample) begin
                s1_key_q <= {pix_r[7:6], pix_g[7:6], pix_b[7:6]};
                s1_x_q   <= sx;
                s1_y_q   <= sy;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_addr_q <= addr_calc;
                s2_idx_q  <= enc_idx;
            end
            if (arm) begin
                overflow_q <= 1'b0;
                miss_q     <= '0;
            end else begin
                if (s2_vld_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;
                if (s1_vld_q && !enc_hit && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign fifo_pop = fb_we && fb_ready;

    fb_capture_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .push_i     (s2_vld_q),
        .push_dat_i ({s2_addr_q, s2_idx_q}),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Head is gated so an idle port never shows unwritten RAM contents.
    assign fb_we      = !fifo_empty;
    assign fb_addr    = fb_we ? fifo_head[FW-1:4] : '0;
    assign fb_data    = fb_we ? fifo_head[3:0] : '0;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign miss_count = miss_q;
endmodule
